// File: rtl/jtcps2_oram_resp.sv
// jtcps2_oram_resp
// Responder for the CPS2 object frame copier's ORAM fetch port. Holds the
// 8K x 16 object RAM (bank = address bit 12) behind a single-port, three
// register pipeline shared by the main CPU (priority) and the copier.
//   edge k   : issue captured (stage 0)
//   edge k+1 : memory access, read data registered (stage 1)
//   edge k+2 : CPU / copier output registers loaded (stage 2)
module jtcps2_oram_resp #(
    parameter int AW        = 13,
    parameter     INIT_FILE = ""
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          cpu_cs,
    input  logic          cpu_we,
    input  logic [AW-1:0] cpu_addr,
    input  logic [1:0]    cpu_dsn,
    input  logic [15:0]   cpu_dout,
    output logic [15:0]   cpu_din,
    output logic          cpu_ok,
    input  logic [AW-1:0] oram_addr,
    output logic [15:0]   oram_data,
    output logic          oram_ok
);

    localparam int DEPTH = 2 ** AW;

    logic [15:0]   mem [0:DEPTH-1];
    logic [15:0]   mem_q;

    // Arbitration / copier bookkeeping
    logic          cpu_busy;
    logic          refresh;
    logic          ok_reg;
    logic [AW-1:0] pending_addr;
    logic [AW-1:0] data_addr;

    // Stage 0 (issue) registers
    logic          s0_valid;
    logic          s0_cpu;
    logic          s0_we;
    logic [AW-1:0] s0_addr;
    logic [1:0]    s0_dsn;
    logic [15:0]   s0_wdata;

    // Stage 1 (memory output) registers
    logic          s1_valid;
    logic          s1_cpu;
    logic          s1_we;
    logic [AW-1:0] s1_addr;

    // Combinational decisions
    logic          cpu_issue;
    logic          cop_issue;
    logic          collide;
    logic          cop_latest;

    // Issue arbitration: CPU wins; copier issues when its address moved or a re-read is owed
    always_comb begin
        cpu_issue  = 1'b0;
        cop_issue  = 1'b0;
        collide    = 1'b0;
        cop_latest = 1'b0;
        cpu_issue  = cpu_cs & ~cpu_busy & ~cpu_ok;
        cop_issue  = ~cpu_issue & ((oram_addr != pending_addr) | refresh);
        // A write to the word the copier holds or is fetching invalidates it
        collide    = cpu_issue & cpu_we &
                     ((cpu_addr == data_addr) | (cpu_addr == pending_addr));
        // Only the newest copier fetch may publish data: no younger copier
        // fetch in flight or issuing now, and no re-read still owed
        cop_latest = s1_valid & ~s1_cpu & ~(s0_valid & ~s0_cpu) & ~cop_issue & ~refresh;
    end

    // oram_ok never flags data belonging to another address, even mid-change
    assign oram_ok = ok_reg & (oram_addr == data_addr);

    // Pipeline stage 0 and 1 registers; reset drops the valid bits to abandon in-flight work
    always_ff @(posedge clk) begin
        if (rst) begin
            s0_valid <= 1'b0;
            s0_cpu   <= 1'b0;
            s0_we    <= 1'b0;
            s0_addr  <= {AW{1'b0}};
            s0_dsn   <= 2'b11;
            s0_wdata <= 16'h0000;
            s1_valid <= 1'b0;
            s1_cpu   <= 1'b0;
            s1_we    <= 1'b0;
            s1_addr  <= {AW{1'b0}};
        end else begin
            s0_valid <= cpu_issue | cop_issue;
            s0_cpu   <= cpu_issue;
            s0_we    <= cpu_issue & cpu_we;
            s0_addr  <= cpu_issue ? cpu_addr : oram_addr;
            s0_dsn   <= cpu_dsn;
            s0_wdata <= cpu_dout;
            s1_valid <= s0_valid;
            s1_cpu   <= s0_cpu;
            s1_we    <= s0_we;
            s1_addr  <= s0_addr;
        end
    end

    // Single memory port: byte-masked write or registered read; contents survive reset
    always_ff @(posedge clk) begin
        if (!rst && s0_valid && s0_we) begin
            if (!s0_dsn[1]) begin
                mem[s0_addr][15:8] <= s0_wdata[15:8];
            end
            if (!s0_dsn[0]) begin
                mem[s0_addr][7:0] <= s0_wdata[7:0];
            end
        end
        mem_q <= mem[s0_addr];
    end

    // CPU handshake and copier address tracking
    always_ff @(posedge clk) begin
        if (rst) begin
            cpu_busy     <= 1'b0;
            refresh      <= 1'b1;   // fetch whatever oram_addr shows once out of reset
            pending_addr <= {AW{1'b0}};
        end else begin
            if (cpu_issue) begin
                cpu_busy <= 1'b1;
            end else if (cpu_ok && !cpu_cs) begin
                cpu_busy <= 1'b0;
            end
            if (collide) begin
                refresh <= 1'b1;
            end else if (cop_issue) begin
                refresh <= 1'b0;
            end
            if (cop_issue) begin
                pending_addr <= oram_addr;
            end
        end
    end

    // Stage 2: load CPU and copier result registers
    always_ff @(posedge clk) begin
        if (rst) begin
            cpu_ok    <= 1'b0;
            cpu_din   <= 16'h0000;
            oram_data <= 16'h0000;
            data_addr <= {AW{1'b0}};
            ok_reg    <= 1'b0;
        end else begin
            if (s1_valid && s1_cpu) begin
                cpu_ok <= 1'b1;
            end else if (!cpu_cs) begin
                cpu_ok <= 1'b0;
            end
            if (s1_valid && s1_cpu && !s1_we) begin
                cpu_din <= mem_q;
            end
            if (cop_latest) begin
                oram_data <= mem_q;
                data_addr <= s1_addr;
            end
            if (collide) begin
                ok_reg <= 1'b0;
            end else if (cop_latest) begin
                ok_reg <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_jtcps2_oram_resp.sv
// Scoreboard bench for jtcps2_oram_resp: drivers push expected responses,
// a monitor pops them when cpu_ok / oram_ok rise. Expected data comes from a
// plain word-array model of the object RAM with byte-enable writes.
module tb_jtcps2_oram_resp;

    localparam int AW = 13;

    logic          clk = 1'b0;
    logic          rst;
    logic          cpu_cs;
    logic          cpu_we;
    logic [AW-1:0] cpu_addr;
    logic [1:0]    cpu_dsn;
    logic [15:0]   cpu_dout;
    logic [15:0]   cpu_din;
    logic          cpu_ok;
    logic [AW-1:0] oram_addr;
    logic [15:0]   oram_data;
    logic          oram_ok;

    always #5 clk = ~clk;

    jtcps2_oram_resp #(.AW(AW), .INIT_FILE("")) dut (
        .clk       (clk),
        .rst       (rst),
        .cpu_cs    (cpu_cs),
        .cpu_we    (cpu_we),
        .cpu_addr  (cpu_addr),
        .cpu_dsn   (cpu_dsn),
        .cpu_dout  (cpu_dout),
        .cpu_din   (cpu_din),
        .cpu_ok    (cpu_ok),
        .oram_addr (oram_addr),
        .oram_data (oram_data),
        .oram_ok   (oram_ok)
    );

    typedef struct {
        bit          is_read;
        logic [15:0] data;
    } cpu_exp_t;

    int          tests = 0;
    int          fails = 0;
    logic [15:0] model [0:8191];
    cpu_exp_t    cpu_q[$];
    logic [15:0] cop_q[$];
    bit          cop_track = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    function automatic void model_write(input logic [AW-1:0] a, input logic [1:0] dsn,
                                        input logic [15:0] d);
        if (!dsn[1]) model[a][15:8] = d[15:8];
        if (!dsn[0]) model[a][7:0]  = d[7:0];
    endfunction

    function automatic logic [AW-1:0] rand_addr();
        if ($urandom_range(0, 15) == 0) return 13'h1FFF;
        return 13'($urandom_range(0, 32'h10FF));
    endfunction

    // Monitor: every rising cpu_ok / oram_ok consumes one expectation
    initial begin : monitor
        bit       prev_cpu_ok;
        bit       prev_oram_ok;
        cpu_exp_t e;
        prev_cpu_ok  = 1'b0;
        prev_oram_ok = 1'b0;
        forever begin
            @(negedge clk);
            #2;
            if (cpu_ok && !prev_cpu_ok) begin
                tests++;
                if (cpu_q.size() == 0) begin
                    fails++;
                    $display("FAIL cpu_ok_unexpected: got a rise, expected none");
                end else begin
                    e = cpu_q.pop_front();
                    if (e.is_read) check("cpu_read_data", 32'(cpu_din), 32'(e.data));
                end
            end
            if (cop_track && oram_ok && !prev_oram_ok) begin
                tests++;
                if (cop_q.size() == 0) begin
                    fails++;
                    $display("FAIL oram_ok_unexpected: got a rise at %h, expected none", oram_addr);
                end else begin
                    check("oram_data", 32'(oram_data), 32'(cop_q.pop_front()));
                end
            end
            prev_cpu_ok  = cpu_ok;
            prev_oram_ok = oram_ok;
        end
    end

    // Plain CPU access with handshake and latency checks
    task automatic cpu_op(input bit we, input logic [AW-1:0] a, input logic [1:0] dsn,
                          input logic [15:0] d, input bit drop_early);
        cpu_exp_t e;
        int n;
        n = 0;
        e.is_read = !we;
        e.data    = model[a];
        if (we) model_write(a, dsn, d);
        cpu_q.push_back(e);
        @(negedge clk);
        cpu_cs = 1'b1; cpu_we = we; cpu_addr = a; cpu_dsn = dsn; cpu_dout = d;
        while (!cpu_ok && n < 20) begin
            @(negedge clk);
            n++;
            if (drop_early && n == 1) cpu_cs = 1'b0;
        end
        check("cpu_latency", 32'(n), 32'd3);
        if (!drop_early) begin
            @(negedge clk);
            check("cpu_ok_hold", 32'(cpu_ok), 32'd1);
        end
        cpu_cs = 1'b0;
        @(negedge clk);
        check("cpu_ok_clear", 32'(cpu_ok), 32'd0);
    endtask

    // Optional CPU access and/or copier address change in the same cycle
    task automatic dual(input bit do_cpu, input bit we, input logic [AW-1:0] caddr,
                        input logic [1:0] dsn, input logic [15:0] d,
                        input bit do_cop, input logic [AW-1:0] oaddr, input bit exp_cop,
                        input int exp_cn, input int exp_on);
        cpu_exp_t e;
        int  n;
        int  cn;
        int  on;
        bit  seen_low;
        n = 0; cn = 0; on = 0; seen_low = 1'b0;
        if (do_cpu) begin
            e.is_read = !we;
            e.data    = model[caddr];
            if (we) model_write(caddr, dsn, d);
            cpu_q.push_back(e);
        end
        if (exp_cop) cop_q.push_back(model[do_cop ? oaddr : oram_addr]);
        @(negedge clk);
        if (do_cpu) begin
            cpu_cs = 1'b1; cpu_we = we; cpu_addr = caddr; cpu_dsn = dsn; cpu_dout = d;
        end
        if (do_cop) begin
            oram_addr = oaddr;
            #1;
            check("oram_ok_drop", 32'(oram_ok), 32'd0);
        end
        while (((do_cpu && cn == 0) || (exp_cop && on == 0)) && n < 30) begin
            @(negedge clk);
            n++;
            if (exp_cop && !do_cop && n == 1) check("collide_drop", 32'(oram_ok), 32'd0);
            if (do_cpu && cn == 0 && cpu_ok) begin
                cn = n;
                cpu_cs = 1'b0;
            end
            if (!oram_ok) seen_low = 1'b1;
            else if (exp_cop && on == 0 && seen_low) on = n;
        end
        cpu_cs = 1'b0;
        if (do_cpu)  check("cpu_latency", 32'(cn), 32'(exp_cn));
        if (exp_cop) check("oram_latency", 32'(on), 32'(exp_on));
        @(negedge clk);
        check("cpu_ok_clear", 32'(cpu_ok), 32'd0);
    endtask

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin : stimulus
        int n;
        int op;
        logic [AW-1:0] a;
        logic [15:0]   d;
        logic [1:0]    m;
        logic [1:0]    m_nz;

        rst = 1'b1; cpu_cs = 1'b0; cpu_we = 1'b0; cpu_addr = 13'h0000;
        cpu_dsn = 2'b11; cpu_dout = 16'h0000; oram_addr = 13'h0000;
        repeat (3) @(negedge clk);
        check("rst_cpu_ok",    32'(cpu_ok),    32'd0);
        check("rst_cpu_din",   32'(cpu_din),   32'd0);
        check("rst_oram_data", 32'(oram_data), 32'd0);
        check("rst_oram_ok",   32'(oram_ok),   32'd0);
        rst = 1'b0;

        // Preload through the CPU port (copier results not tracked meanwhile)
        for (int i = 0; i < 32'h1100; i++) begin
            cpu_op(1'b1, 13'(i), 2'b00, (i == 16) ? 16'hBEEF : 16'($urandom), 1'b0);
        end
        cpu_op(1'b1, 13'h1FFF, 2'b00, 16'($urandom), 1'b0);

        // Reset with oram_addr held at 0x0010: two quiet cycles, then the word
        @(negedge clk);
        rst = 1'b1;
        oram_addr = 13'h0010;
        repeat (2) @(negedge clk);
        check("rst_hold_oram_ok", 32'(oram_ok), 32'd0);
        cop_q.push_back(model[16]);
        cop_track = 1'b1;
        rst = 1'b0;
        n = 0;
        while (!oram_ok && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("post_reset_oram_latency", 32'(n), 32'd3);

        // Byte-enable merge: 0x1234 full, then 0xAB55 upper byte only -> 0xAB34
        cpu_op(1'b1, 13'h1005, 2'b00, 16'h1234, 1'b0);
        cpu_op(1'b1, 13'h1005, 2'b01, 16'hAB55, 1'b0);
        cpu_op(1'b0, 13'h1005, 2'b00, 16'h0000, 1'b0);

        // Copier sweep over bank 0, advancing only once oram_ok is seen
        for (int i = 0; i < 32'h1000; i++) begin
            dual(1'b0, 1'b0, 13'h0000, 2'b11, 16'h0000, 1'b1, 13'(i), 1'b1, 0, 3);
        end

        // Address wrap 0x1FFF -> 0x0000
        dual(1'b0, 1'b0, 13'h0000, 2'b11, 16'h0000, 1'b1, 13'h1FFF, 1'b1, 0, 3);
        dual(1'b0, 1'b0, 13'h0000, 2'b11, 16'h0000, 1'b1, 13'h0000, 1'b1, 0, 3);

        // CPU write into the word the copier holds
        dual(1'b0, 1'b0, 13'h0000, 2'b11, 16'h0000, 1'b1, 13'h0200, 1'b1, 0, 3);
        dual(1'b1, 1'b1, 13'h0200, 2'b00, 16'h5A5A, 1'b0, 13'h0000, 1'b1, 3, 4);

        // CPU read and copier change in the same cycle: copier one cycle late
        dual(1'b1, 1'b0, 13'h1005, 2'b00, 16'h0000, 1'b1, 13'h0300, 1'b1, 3, 4);

        // cs dropped mid-access (1-cycle cpu_ok pulse), and a dsn=11 no-op write
        cpu_op(1'b1, 13'h0400, 2'b10, 16'hC3C3, 1'b1);
        cpu_op(1'b0, 13'h0400, 2'b00, 16'h0000, 1'b0);
        cpu_op(1'b1, 13'h0401, 2'b11, 16'hFFFF, 1'b0);
        cpu_op(1'b0, 13'h0401, 2'b00, 16'h0000, 1'b0);

        // Reset one cycle after a CPU read issue abandons it
        cop_track = 1'b0;
        @(negedge clk);
        cpu_cs = 1'b1; cpu_we = 1'b0; cpu_addr = 13'h0010; cpu_dsn = 2'b00;
        @(negedge clk);
        rst = 1'b1;
        cpu_cs = 1'b0;
        repeat (3) begin
            @(negedge clk);
            check("rst_mid_cpu_ok", 32'(cpu_ok), 32'd0);
        end
        check("rst_mid_cpu_din", 32'(cpu_din), 32'd0);
        rst = 1'b0;
        repeat (6) begin
            @(negedge clk);
            check("rst_mid_no_late_ok", 32'(cpu_ok), 32'd0);
        end
        cop_track = 1'b1;
        cpu_op(1'b0, 13'h0010, 2'b00, 16'h0000, 1'b0);

        // Randomized mix
        for (int i = 0; i < 300; i++) begin
            op   = $urandom_range(0, 4);
            a    = rand_addr();
            d    = 16'($urandom);
            m    = 2'($urandom_range(0, 3));
            m_nz = 2'($urandom_range(0, 2));
            case (op)
                0: cpu_op(1'b0, a, 2'b00, 16'h0000, 1'b0);
                1: begin
                    if (a != oram_addr) cpu_op(1'b1, a, m, d, 1'($urandom_range(0, 1)));
                    else cpu_op(1'b0, a, 2'b00, 16'h0000, 1'b0);
                end
                2: begin
                    if (a != oram_addr)
                        dual(1'b0, 1'b0, 13'h0000, 2'b11, 16'h0000, 1'b1, a, 1'b1, 0, 3);
                end
                3: begin
                    if (a != oram_addr)
                        dual(1'b1, 1'b1, a, m_nz, d, 1'b1, a, 1'b1, 3, 4);
                end
                4: dual(1'b1, 1'b1, oram_addr, m_nz, d, 1'b0, 13'h0000, 1'b1, 3, 4);
                default: ;
            endcase
        end

        repeat (4) @(negedge clk);
        check("cpu_queue_drained", 32'(cpu_q.size()), 32'd0);
        check("oram_queue_drained", 32'(cop_q.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
